// File: rtl/fetch_ras.sv
// Fetch stage with program counter, next-PC selection and an internal return-address stack.
// Optional macro FETCH_RAS_CIRCULAR_EN: a push onto a full stack overwrites the oldest entry instead of being dropped.
module fetch_ras #(
    parameter int ADDR_W = 14,
    parameter int RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [1:0]                   pc_sel,
    input  logic                         call,
    input  logic [ADDR_W-1:0]            branch_target_addr,
    input  logic [ADDR_W-1:0]            int_branch_addr,
    output logic [ADDR_W-1:0]            prog_mem_fetch_read_addr,
    output logic [ADDR_W-1:0]            ret_addr_out,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [PTR_W-1:0]  top_idx;
    logic              push_req;
    logic              push_en;
    logic [ADDR_W-1:0] push_val;

    assign pc_inc  = pc_q + 1'b1;
    // ptr_q is the next free slot; the most recent entry sits just below it
    assign top_idx = ptr_q - 1'b1;

    always_comb begin
        pc_d     = pc_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        push_req = 1'b0;
        push_en  = 1'b0;
        push_val = pc_inc;

        if (!stall) begin
            case (pc_sel)
                2'b00: pc_d = pc_inc;
                2'b01: begin
                    pc_d     = branch_target_addr;
                    push_req = call;
                end
                2'b10: begin
                    if (cnt_q != '0) begin
                        pc_d  = ras_q[top_idx];
                        ptr_d = top_idx;
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end
                end
                default: begin
                    // Interrupted instruction is squashed, so it must be re-fetched on return
                    pc_d     = int_branch_addr;
                    push_req = 1'b1;
                    push_val = pc_q;
                end
            endcase
        end

        if (push_req) begin
            if (cnt_q == FULL_CNT) begin
                ovf_d = 1'b1;
`ifdef FETCH_RAS_CIRCULAR_EN
                push_en = 1'b1;
                ptr_d   = ptr_q + 1'b1;
`else
                push_en = 1'b0;
`endif
            end else begin
                push_en = 1'b1;
                ptr_d   = ptr_q + 1'b1;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage carries no reset; only the pointer and count define validity
    always_ff @(posedge clock) begin
        if (push_en && !reset) begin
            ras_q[ptr_q] <= push_val;
        end
    end

    assign prog_mem_fetch_read_addr = pc_q;
    assign ret_addr_out             = pc_inc;
    assign ras_count                = cnt_q;
    assign ras_overflow             = ovf_q;
    assign ras_underflow            = unf_q;

endmodule

// File: tb/tb_fetch_ras.sv
// Bench for fetch_ras: directed vector table, hand-written stack corner sequences, and a randomized run against a queue model.
module tb_fetch_ras;

    localparam int AW    = 14;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic [1:0]    pc_sel = 2'b00;
    logic          call = 1'b0;
    logic [AW-1:0] bta = '0;
    logic [AW-1:0] iba = '0;
    logic [AW-1:0] fetch_addr;
    logic [AW-1:0] ret_addr;
    logic [CW-1:0] ras_count;
    logic          ras_overflow;
    logic          ras_underflow;

    int checks   = 0;
    int failures = 0;

    fetch_ras #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_VECTOR('0)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .stall                    (stall),
        .pc_sel                   (pc_sel),
        .call                     (call),
        .branch_target_addr       (bta),
        .int_branch_addr          (iba),
        .prog_mem_fetch_read_addr (fetch_addr),
        .ret_addr_out             (ret_addr),
        .ras_count                (ras_count),
        .ras_overflow             (ras_overflow),
        .ras_underflow            (ras_underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          r;
        logic          s;
        logic [1:0]    sel;
        logic          c;
        logic [AW-1:0] t;
        logic [AW-1:0] v;
        logic [AW-1:0] pc;
        int            cnt;
        logic          o;
        logic          u;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic [1:0] sel, logic c, logic [AW-1:0] t,
                                logic [AW-1:0] v, logic [AW-1:0] pc, int cnt, logic o, logic u);
        vec_t x;
        x.r = r; x.s = s; x.sel = sel; x.c = c; x.t = t; x.v = v;
        x.pc = pc; x.cnt = cnt; x.o = o; x.u = u;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [1:0] sel, input logic c,
                       input logic [AW-1:0] t, input logic [AW-1:0] v);
        reset = r; stall = s; pc_sel = sel; call = c; bta = t; iba = v;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_state(input string nm, input logic [AW-1:0] pc, input int cnt,
                             input logic o, input logic u);
        logic [AW-1:0] nxt;
        nxt = pc + 1'b1;
        chk({nm, ".pc"}, 32'(fetch_addr), 32'(pc));
        chk({nm, ".cnt"}, 32'(ras_count), 32'(cnt));
        chk({nm, ".ovf"}, 32'(ras_overflow), 32'(o));
        chk({nm, ".unf"}, 32'(ras_underflow), 32'(u));
        chk({nm, ".ret"}, 32'(ret_addr), 32'(nxt));
    endtask

    // Reference model: stack as a queue, newest entry at the back
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_q[$];
    logic          m_o, m_u;

    task automatic m_push(input logic [AW-1:0] a);
        if (m_q.size() == DEPTH) begin
            m_o = 1'b1;
`ifdef FETCH_RAS_CIRCULAR_EN
            void'(m_q.pop_front());
            m_q.push_back(a);
`endif
        end else begin
            m_q.push_back(a);
        end
    endtask

    task automatic m_step(input logic r, input logic s, input logic [1:0] sel, input logic c,
                          input logic [AW-1:0] t, input logic [AW-1:0] v);
        logic [AW-1:0] old;
        old = m_pc;
        m_o = 1'b0;
        m_u = 1'b0;
        if (r) begin
            m_pc = '0;
            m_q.delete();
        end else if (!s) begin
            case (sel)
                2'd0: m_pc = old + 1'b1;
                2'd1: begin
                    if (c) m_push(old + 1'b1);
                    m_pc = t;
                end
                2'd2: begin
                    if (m_q.size() > 0) m_pc = m_q.pop_back();
                    else begin
                        m_pc = old + 1'b1;
                        m_u  = 1'b1;
                    end
                end
                default: begin
                    m_push(old);
                    m_pc = v;
                end
            endcase
        end
    endtask

    initial begin
        logic [AW-1:0] pop_base;
        logic [AW-1:0] exp_pc;

        tbl.push_back(mk(1, 0, 2'd0, 0, 14'h0000, 14'h0000, 14'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd0, 0, 14'h0000, 14'h0000, 14'h0001, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd0, 0, 14'h0000, 14'h0000, 14'h0002, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd0, 0, 14'h0000, 14'h0000, 14'h0003, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd1, 0, 14'h0010, 14'h0000, 14'h0010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd1, 1, 14'h0200, 14'h0000, 14'h0200, 1, 0, 0));
        tbl.push_back(mk(0, 0, 2'd2, 0, 14'h0000, 14'h0000, 14'h0011, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd1, 0, 14'h0040, 14'h0000, 14'h0040, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd3, 0, 14'h0000, 14'h3F00, 14'h3F00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 2'd0, 0, 14'h0000, 14'h0000, 14'h3F01, 1, 0, 0));
        tbl.push_back(mk(0, 0, 2'd2, 0, 14'h0000, 14'h0000, 14'h0040, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd1, 0, 14'h3FFF, 14'h0000, 14'h3FFF, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd2, 0, 14'h0000, 14'h0000, 14'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 2'd0, 1, 14'h0000, 14'h0000, 14'h0001, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd1, 1, 14'h0200, 14'h0000, 14'h0001, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd1, 1, 14'h3FFF, 14'h0000, 14'h3FFF, 1, 0, 0));
        tbl.push_back(mk(0, 0, 2'd1, 1, 14'h0123, 14'h0000, 14'h0123, 2, 0, 0));
        tbl.push_back(mk(0, 0, 2'd2, 0, 14'h0000, 14'h0000, 14'h0000, 1, 0, 0));
        tbl.push_back(mk(0, 0, 2'd2, 0, 14'h0000, 14'h0000, 14'h0002, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd3, 1, 14'h0555, 14'h2000, 14'h2000, 1, 0, 0));
        tbl.push_back(mk(0, 0, 2'd2, 1, 14'h0555, 14'h0000, 14'h0002, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].sel, tbl[i].c, tbl[i].t, tbl[i].v);
            chk_state($sformatf("vec%0d", i), tbl[i].pc, tbl[i].cnt, tbl[i].o, tbl[i].u);
        end

        // Nine nested calls into an eight-entry stack, then unwind
        cyc(1, 0, 2'd0, 0, '0, '0);
        cyc(0, 0, 2'd1, 0, 14'h0100, '0);
        chk_state("ovf.start", 14'h0100, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 2'd1, 1, 14'(14'h0101 + i), '0);
            chk_state($sformatf("ovf.call%0d", i), 14'(14'h0101 + i),
                      (i + 1 > DEPTH) ? DEPTH : i + 1, (i == 8), 0);
        end
`ifdef FETCH_RAS_CIRCULAR_EN
        pop_base = 14'h0109;
`else
        pop_base = 14'h0108;
`endif
        for (int j = 0; j < 8; j++) begin
            cyc(0, 0, 2'd2, 0, '0, '0);
            chk_state($sformatf("ovf.pop%0d", j), 14'(pop_base - j), 7 - j, 0, 0);
        end
        exp_pc = pop_base - 14'd7 + 14'd1;
        cyc(0, 0, 2'd2, 0, '0, '0);
        chk_state("ovf.under", exp_pc, 0, 0, 1);
        cyc(0, 0, 2'd0, 0, '0, '0);
        chk_state("ovf.clear", exp_pc + 14'd1, 0, 0, 0);

        // Stall freezes a populated stack; reset overrides stall
        cyc(1, 0, 2'd0, 0, '0, '0);
        cyc(0, 0, 2'd1, 0, 14'h0050, '0);
        cyc(0, 0, 2'd1, 1, 14'h0060, '0);
        cyc(0, 0, 2'd1, 1, 14'h0070, '0);
        cyc(0, 0, 2'd1, 1, 14'h0080, '0);
        chk_state("stall.pre", 14'h0080, 3, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 2'd1, 1, 14'h0999, '0);
            chk_state($sformatf("stall.hold%0d", k), 14'h0080, 3, 0, 0);
        end
        cyc(1, 1, 2'd1, 1, 14'h0999, '0);
        chk_state("stall.reset", 14'h0000, 0, 0, 0);
        cyc(0, 0, 2'd2, 0, '0, '0);
        chk_state("stall.empty", 14'h0001, 0, 0, 1);

        // Randomized run against the queue model
        cyc(1, 0, 2'd0, 0, '0, '0);
        m_step(1, 0, 2'd0, 0, '0, '0);
        for (int n = 0; n < 3000; n++) begin
            logic          r, s, c;
            logic [1:0]    sel;
            logic [AW-1:0] t, v;
            int            p;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 15);
            p = $urandom_range(0, 99);
            sel = (p < 20) ? 2'd0 : (p < 55) ? 2'd1 : (p < 85) ? 2'd2 : 2'd3;
            c = ($urandom_range(0, 99) < 75);
            t = AW'($urandom);
            v = AW'($urandom);
            cyc(r, s, sel, c, t, v);
            m_step(r, s, sel, c, t, v);
            chk_state($sformatf("rnd%0d", n), m_pc, m_q.size(), m_o, m_u);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
